// File: rtl/pipe_stage_skid.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_stage_skid                                              |
// | Description : Inter-stage pipeline register (instr/PC/data/regaddr/        |
// |               regwrite) with valid/ready handshake and a 2-entry skid      |
// |               buffer. in_ready is registered so no combinational path      |
// |               runs from out_ready back to upstream. Synchronous flush      |
// |               clears both entries. Optional stall-cycle counter is         |
// |               enabled by defining PIPE_STAGE_STALL_CNT_EN.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pipe_stage_skid #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_instr,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] in_regaddr,
  input  logic              in_regwrite,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_instr,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_regaddr,
  output logic              out_regwrite,
  output logic [1:0]        occupancy,
  output logic [31:0]       stall_cnt
);

  // Main entry: drives the outputs.
  logic              main_valid_q,    main_valid_d;
  logic [PC_W-1:0]   main_instr_q,    main_instr_d;
  logic [PC_W-1:0]   main_pc_q,       main_pc_d;
  logic [DATA_W-1:0] main_data_q,     main_data_d;
  logic [ADDR_W-1:0] main_regaddr_q,  main_regaddr_d;
  logic              main_regwrite_q, main_regwrite_d;

  // Skid entry: catches the one in-flight input when main is blocked.
  logic              skid_valid_q,    skid_valid_d;
  logic [PC_W-1:0]   skid_instr_q,    skid_instr_d;
  logic [PC_W-1:0]   skid_pc_q,       skid_pc_d;
  logic [DATA_W-1:0] skid_data_q,     skid_data_d;
  logic [ADDR_W-1:0] skid_regaddr_q,  skid_regaddr_d;
  logic              skid_regwrite_q, skid_regwrite_d;

  logic accept;
  logic drain;

  // Handshake qualifiers; in_ready comes straight from the skid flop.
  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & ~skid_valid_q;
  assign drain    = main_valid_q & out_ready;

  // Next-state: flush wins, then main refill (skid first for FIFO order), else spill to skid.
  always_comb begin
    main_valid_d    = main_valid_q;
    main_instr_d    = main_instr_q;
    main_pc_d       = main_pc_q;
    main_data_d     = main_data_q;
    main_regaddr_d  = main_regaddr_q;
    main_regwrite_d = main_regwrite_q;
    skid_valid_d    = skid_valid_q;
    skid_instr_d    = skid_instr_q;
    skid_pc_d       = skid_pc_q;
    skid_data_d     = skid_data_q;
    skid_regaddr_d  = skid_regaddr_q;
    skid_regwrite_d = skid_regwrite_q;

    if (flush) begin
      main_valid_d    = 1'b0;
      main_instr_d    = '0;
      main_pc_d       = '0;
      main_data_d     = '0;
      main_regaddr_d  = '0;
      main_regwrite_d = 1'b0;
      skid_valid_d    = 1'b0;
      skid_instr_d    = '0;
      skid_pc_d       = '0;
      skid_data_d     = '0;
      skid_regaddr_d  = '0;
      skid_regwrite_d = 1'b0;
    end else if (!main_valid_q || drain) begin
      if (skid_valid_q) begin
        // Older skid entry moves forward before any newer input.
        main_valid_d    = 1'b1;
        main_instr_d    = skid_instr_q;
        main_pc_d       = skid_pc_q;
        main_data_d     = skid_data_q;
        main_regaddr_d  = skid_regaddr_q;
        main_regwrite_d = skid_regwrite_q;
        skid_valid_d    = accept;
        if (accept) begin
          skid_instr_d    = in_instr;
          skid_pc_d       = in_pc;
          skid_data_d     = in_data;
          skid_regaddr_d  = in_regaddr;
          skid_regwrite_d = in_regwrite;
        end
      end else begin
        main_valid_d = accept;
        if (accept) begin
          main_instr_d    = in_instr;
          main_pc_d       = in_pc;
          main_data_d     = in_data;
          main_regaddr_d  = in_regaddr;
          main_regwrite_d = in_regwrite;
        end
      end
    end else if (accept) begin
      // Main is held: park the new entry in the skid slot.
      skid_valid_d    = 1'b1;
      skid_instr_d    = in_instr;
      skid_pc_d       = in_pc;
      skid_data_d     = in_data;
      skid_regaddr_d  = in_regaddr;
      skid_regwrite_d = in_regwrite;
    end
  end

  // Entry registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_valid_q    <= 1'b0;
      main_instr_q    <= '0;
      main_pc_q       <= '0;
      main_data_q     <= '0;
      main_regaddr_q  <= '0;
      main_regwrite_q <= 1'b0;
      skid_valid_q    <= 1'b0;
      skid_instr_q    <= '0;
      skid_pc_q       <= '0;
      skid_data_q     <= '0;
      skid_regaddr_q  <= '0;
      skid_regwrite_q <= 1'b0;
    end else begin
      main_valid_q    <= main_valid_d;
      main_instr_q    <= main_instr_d;
      main_pc_q       <= main_pc_d;
      main_data_q     <= main_data_d;
      main_regaddr_q  <= main_regaddr_d;
      main_regwrite_q <= main_regwrite_d;
      skid_valid_q    <= skid_valid_d;
      skid_instr_q    <= skid_instr_d;
      skid_pc_q       <= skid_pc_d;
      skid_data_q     <= skid_data_d;
      skid_regaddr_q  <= skid_regaddr_d;
      skid_regwrite_q <= skid_regwrite_d;
    end
  end

  assign out_valid    = main_valid_q;
  assign out_instr    = main_instr_q;
  assign out_pc       = main_pc_q;
  assign out_data     = main_data_q;
  assign out_regaddr  = main_regaddr_q;
  // A bubble must never write the register file.
  assign out_regwrite = main_regwrite_q & main_valid_q;
  assign occupancy    = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Saturating count of cycles where a valid output is back-pressured; flush does not clear it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= 32'd0;
    end else if (main_valid_q && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pipe_stage_skid                                           |
// | Description : Scoreboard bench for pipe_stage_skid. A 2-deep FIFO model    |
// |               holds expected entries; a negedge monitor compares outputs.  |
// |               Honours PIPE_STAGE_STALL_CNT_EN for the stall counter.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pipe_stage_skid;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] data;
    logic [4:0]  addr;
    logic        we;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_data = '0;
  logic [4:0]  in_regaddr = '0;
  logic        in_regwrite = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_data;
  logic [4:0]  out_regaddr;
  logic        out_regwrite;
  logic [1:0]  occupancy;
  logic [31:0] stall_cnt;

  pipe_stage_skid #(.DATA_W(32), .ADDR_W(5), .PC_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_data(in_data),
    .in_regaddr(in_regaddr), .in_regwrite(in_regwrite),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_data(out_data),
    .out_regaddr(out_regaddr), .out_regwrite(out_regwrite),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state
  ent_t        exp_q[$];
  logic [31:0] emitted[$];
  bit          zero_ok = 1'b1;
  logic [31:0] stall_m = 32'd0;
  bit          last_acc = 1'b0;
  bit          m_acc;
  bit          m_drn;
  int          m_sz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a FIFO of capacity 2 whose ready reflects the pre-edge fill level.
  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        exp_q.delete();
        zero_ok  = 1'b1;
        stall_m  = 32'd0;
        last_acc = 1'b0;
      end else begin
        m_sz  = exp_q.size();
        m_acc = in_valid && (m_sz < 2);
        m_drn = (m_sz > 0) && out_ready;
        if ((m_sz > 0) && !out_ready && (stall_m != 32'hFFFF_FFFF)) stall_m = stall_m + 32'd1;
        if (flush) begin
          exp_q.delete();
          zero_ok = 1'b1;
          m_acc   = 1'b0;
        end else begin
          if (m_drn) void'(exp_q.pop_front());
          if (m_acc) begin
            exp_q.push_back('{instr: in_instr, pc: in_pc, data: in_data,
                               addr: in_regaddr, we: in_regwrite});
            zero_ok = 1'b0;
          end
        end
        last_acc = m_acc;
      end
    end
  end

  // Monitor: compare DUT outputs with the head of the expected queue.
  always @(negedge clk) begin
    ent_t e;
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_q.size() < 2});
    chk("occupancy", {30'd0, occupancy}, exp_q.size());
    chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
    if (exp_q.size() > 0) begin
      e = exp_q[0];
      chk("out_instr", out_instr, e.instr);
      chk("out_pc", out_pc, e.pc);
      chk("out_data", out_data, e.data);
      chk("out_regaddr", {27'd0, out_regaddr}, {27'd0, e.addr});
      chk("out_regwrite", {31'd0, out_regwrite}, {31'd0, e.we});
    end else begin
      chk("out_regwrite_idle", {31'd0, out_regwrite}, 32'd0);
      if (zero_ok) begin
        chk("zero_instr", out_instr, 32'd0);
        chk("zero_pc", out_pc, 32'd0);
        chk("zero_data", out_data, 32'd0);
        chk("zero_regaddr", {27'd0, out_regaddr}, 32'd0);
      end
    end
`ifdef PIPE_STAGE_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, stall_m);
`else
    chk("stall_cnt", stall_cnt, 32'd0);
`endif
    if (reset && out_valid && out_ready) emitted.push_back(out_pc);
  end

  // One clock: inputs already set, wait for the edge, settle.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input ent_t e);
    in_valid    = v;
    in_instr    = e.instr;
    in_pc       = e.pc;
    in_data     = e.data;
    in_regaddr  = e.addr;
    in_regwrite = e.we;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Present one entry until the model says it was accepted (bounded).
  task automatic send_one(input ent_t e);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      set_in(1'b1, e);
      cycle();
      done = last_acc;
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  function automatic ent_t mk(input logic [31:0] pc);
    mk = '{instr: pc ^ 32'h0013_0000, pc: pc, data: pc + 32'h100,
           addr: pc[6:2], we: pc[2]};
  endfunction

  ent_t cur;
  bit   have;

  initial begin
    // Reset state
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_occupancy", {30'd0, occupancy}, 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    reset = 1'b1;
    cycle();

    // Stall counter: one entry held for 10 back-pressured cycles
    out_ready = 1'b0;
    send_one(mk(32'h0000_1000));
    idle(10);
`ifdef PIPE_STAGE_STALL_CNT_EN
    chk("stall_10", stall_cnt, 32'd10);
`else
    chk("stall_10", stall_cnt, 32'd0);
`endif

    // Asynchronous reset mid-transfer (main + skid full)
    send_one(mk(32'h0000_1004));
    chk("pre_rst_occ", {30'd0, occupancy}, 32'd2);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_occupancy", {30'd0, occupancy}, 32'd0);
    chk("arst_out_pc", out_pc, 32'd0);
    chk("arst_out_instr", out_instr, 32'd0);
    chk("arst_stall_cnt", stall_cnt, 32'd0);
    cycle();
    reset = 1'b1;
    cycle();

    // Full-throughput stream with out_ready high
    out_ready = 1'b1;
    emitted.delete();
    for (int i = 0; i < 3; i++) begin
      send_one(mk(32'h3000 + 32'(i * 4)));
      chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
    end
    idle(3);
    chk("stream_count", emitted.size(), 32'd3);
    for (int i = 0; i < 3 && i < emitted.size(); i++)
      chk("stream_pc", emitted[i], 32'h3000 + 32'(i * 4));

    // Back-pressure: two held, third waits upstream, then drain in order
    out_ready = 1'b0;
    emitted.delete();
    send_one(mk(32'h3000));
    send_one(mk(32'h3004));
    set_in(1'b1, mk(32'h3008));
    cycle();
    chk("bp_occupancy", {30'd0, occupancy}, 32'd2);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    send_one(mk(32'h3008));
    idle(4);
    chk("bp_count", emitted.size(), 32'd3);
    for (int i = 0; i < 3 && i < emitted.size(); i++)
      chk("bp_pc", emitted[i], 32'h3000 + 32'(i * 4));

    // Flush with occupancy 2 and an input presented
    out_ready = 1'b0;
    send_one(mk(32'h4004));
    send_one(mk(32'h4008));
    flush = 1'b1;
    set_in(1'b1, mk(32'h400C));
    cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_occupancy", {30'd0, occupancy}, 32'd0);
    chk("flush_regwrite", {31'd0, out_regwrite}, 32'd0);
    chk("flush_instr", out_instr, 32'd0);
    emitted.delete();
    out_ready = 1'b1;
    idle(3);
    chk("flush_no_emit", emitted.size(), 32'd0);

    // Register-write entry at the address boundary
    out_ready = 1'b0;
    send_one('{instr: 32'h0000_0013, pc: 32'h5000, data: 32'hDEAD_BEEF, addr: 5'd31, we: 1'b1});
    chk("rw_regwrite", {31'd0, out_regwrite}, 32'd1);
    chk("rw_regaddr", {27'd0, out_regaddr}, 32'd31);
    chk("rw_data", out_data, 32'hDEAD_BEEF);
    out_ready = 1'b1;
    idle(1);
    chk("rw_valid_after", {31'd0, out_valid}, 32'd0);
    chk("rw_regwrite_after", {31'd0, out_regwrite}, 32'd0);

    // Randomised traffic against the model
    have = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!have) begin
        cur  = '{instr: $urandom, pc: $urandom, data: $urandom,
                 addr: 5'($urandom), we: 1'($urandom)};
        have = 1'b1;
      end
      set_in(($urandom % 10) < 7, cur);
      out_ready = ($urandom % 10) < 6;
      flush     = ($urandom % 32) == 0;
      cycle();
      if (last_acc) have = 1'b0;
    end
    flush     = 1'b0;
    out_ready = 1'b1;
    idle(5);
    chk("final_occupancy", {30'd0, occupancy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
